// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  // Instruction presented to decode when nothing valid is buffered (addi x0,x0,0).
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // One prefetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Front-end control state.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, inst} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop_s;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign pop_s   = pop_i && !empty_o;

  // Pointer and occupancy update; flush wins over push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flushed push is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_prefetch_checker.sv
// Protocol and occupancy checks for the prefetch unit.
module fetch_prefetch_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rvalid_i,
  input logic [CW-1:0] inflight_i,
  input logic [CW-1:0] fifo_count_i
);

  // A response with nothing in flight is a memory protocol error; the word is ignored.
  a_rvalid_tracked: assert property (@(posedge clk) disable iff (!rst_n)
    rvalid_i |-> (inflight_i != '0))
    else $error("fetch: rvalid received with no request in flight");

  // Credit accounting must keep the FIFO within its capacity.
  a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_count_i <= CW'(DEPTH))
    else $error("fetch: prefetch FIFO occupancy above capacity");

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: in-order memory requests, prefetch buffer, decode interface.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        de_valid,
  output logic [31:0] de_inst,
  output logic [31:0] de_pc,
  output logic [31:0] de_pc_inc,
  input  logic        de_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          rsp_ok_s;
  logic          gnt_s;
  logic          push_s;
  logic          pop_s;
  logic          credit_ok_s;
  logic [31:0]   redir_target_s;
  fetch_entry_t  push_data_s;
  fetch_entry_t  head_s;
  logic [CW-1:0] fifo_count_s;
  logic          fifo_empty_s;

  // Only responses to tracked requests count; a stray rvalid is ignored.
  assign rsp_ok_s       = imem_rvalid && (inflight_q != '0);
  assign redir_target_s = word_align(redirect_pc);

  // Buffered plus in-flight words may never exceed the FIFO, so pushes cannot overflow.
  assign credit_ok_s = ((SW'(fifo_count_s) + SW'(inflight_q)) < SW'(DEPTH)) &&
                       (inflight_q < CW'(MAX_OUTSTANDING));

  assign imem_req  = (state_q != BOOT) && !redirect && credit_ok_s;
  assign imem_addr = fetch_pc_q;
  assign gnt_s     = imem_req && imem_gnt;

  assign push_s      = rsp_ok_s && (drop_cnt_q == '0) && !redirect;
  assign push_data_s = '{pc: resp_pc_q, inst: imem_rdata};

  assign de_valid = !fifo_empty_s && !redirect;
  assign pop_s    = de_valid && !de_stall;

  // Decode view of the FIFO head; zeros before the first fetch, NOP when merely empty.
  always_comb begin
    de_inst   = 32'h0000_0000;
    de_pc     = 32'h0000_0000;
    de_pc_inc = 32'h0000_0000;
    if (de_valid) begin
      de_inst   = head_s.inst;
      de_pc     = head_s.pc;
      de_pc_inc = head_s.pc + 32'd4;
    end else if (state_q == BOOT) begin
      de_inst = 32'h0000_0000;
    end else begin
      de_inst = NOP_INST;
    end
  end

  // Next-state logic: redirect overrides request, response and state progress.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CW'(gnt_s) - CW'(rsp_ok_s);
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = redir_target_s;
      resp_pc_d  = redir_target_s;
      // Everything still outstanding after this cycle belongs to the old path.
      drop_cnt_d = inflight_q - CW'(rsp_ok_s);
      state_d    = (drop_cnt_d != '0) ? DRAIN : RUN;
    end else begin
      if (gnt_s) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_ok_s && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else if (rsp_ok_s) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = RUN;
        DRAIN:   state_d = (drop_cnt_d == '0) ? RUN : DRAIN;
        default: state_d = BOOT;
      endcase
    end
  end

  // Control and address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .flush_i (redirect),
    .head_o  (head_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s)
  );

  fetch_prefetch_checker #(.DEPTH(DEPTH), .CW(CW)) u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .rvalid_i     (imem_rvalid),
    .inflight_i   (inflight_q),
    .fifo_count_i (fifo_count_s)
  );

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the decode pipeline registers.
- Issues in-order requests to instruction memory over a req/gnt/rvalid handshake and buffers returned words, each with its PC, in a small prefetch FIFO.
- Presents instruction, PC and PC+4 to decode; honours the hazard-unit stall and the branch-unit redirect.
- Replaces the bare PC register plus combinational instruction-memory lookup.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, maximum granted but not yet returned requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, word aligned
imem_gnt  input  1  request accepted this cycle (only meaningful with imem_req)
imem_rvalid  input  1  read data valid; responses return in request order
imem_rdata  input  32  instruction word
de_valid  output  1  FIFO head valid for decode
de_inst  output  32  head instruction
de_pc  output  32  head PC
de_pc_inc  output  32  head PC+4
de_stall  input  1  decode holds (HDU stall); head is not consumed
redirect  input  1  taken branch/jump from execute; flush
redirect_pc  input  32  new fetch target (bits [1:0] ignored, forced 0)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, state=BOOT.
  - Outputs: imem_req=0, imem_addr=RESET_PC, de_valid=0, de_inst/de_pc/de_pc_inc=0.
- State machine:
  - BOOT -> RUN after one cycle with no request issued.
  - RUN -> DRAIN on redirect when inflight-after-cycle>0.
  - DRAIN -> RUN when drop_cnt reaches 0.
  - Any redirect re-enters DRAIN if in-flight responses exist.
- Request issue:
  - imem_req=1 when state!=BOOT, !redirect, and count+inflight<DEPTH, and inflight<MAX_OUTSTANDING.
  - Once asserted, imem_req and imem_addr stay stable until imem_gnt, unless redirect occurs.
  - On gnt: fetch_pc+=4 (wraps modulo 2^32), inflight+=1.
- Response:
  - On rvalid with drop_cnt>0: discard the word and decrement drop_cnt.
  - Otherwise push {resp_pc, imem_rdata} and set resp_pc+=4.
  - inflight decrements on every rvalid.
  - The credit rule guarantees the FIFO never overflows. An rvalid with inflight=0 is a protocol error: flag it with an assertion and ignore the word.
- Output:
  - de_* reflect the FIFO head; de_pc_inc=de_pc+4.
  - Pop when de_valid && !de_stall.
  - Empty FIFO -> de_valid=0; de_inst is driven 32'h0000_0013 (NOP).
  - No bypass: a word returned in cycle N is first visible at N+1.
  - Push and pop in the same cycle keep count unchanged.
- Redirect (wins over everything in its cycle):
  - FIFO flushed; de_valid forced 0 combinationally.
  - imem_req forced 0 that cycle.
  - fetch_pc and resp_pc set to redirect_pc.
  - drop_cnt set to inflight minus (rvalid?1:0); any rvalid word in the redirect cycle is discarded.
  - Redirect during DRAIN recomputes drop_cnt the same way.
  - Stall is ignored in the redirect cycle.
- Stall: no pop; fetching continues until credits are exhausted.
- Reset mid-operation clears all state; responses arriving after reset release belong to the memory's own reset domain and are not tracked.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INST constant (32'h0000_0013).
  - fetch_entry_t struct {pc[31:0], inst[31:0]}.
  - fetch_state_e enum {BOOT, RUN, DRAIN}.
- One sub-module fetch_fifo:
  - Parameterised DEPTH of fetch_entry_t with push/pop/flush/count/empty.
  - Async active-low reset.
  - Pointer wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Test Plan:
- Reset release, gnt tied 1, rvalid one cycle after gnt, rdata=addr, de_stall=0 -> requests at 0,4,8…; de_valid from cycle 3 with de_pc=0, de_inst=0, de_pc_inc=4; one instruction per cycle sustained.
- de_stall held 10 cycles, DEPTH=4 -> at most 4 buffered, imem_req drops to 0, de_pc frozen; release -> four consecutive PCs delivered with no gap or duplicate.
- imem_gnt low 3 cycles with req pending -> imem_addr stable across all 3 cycles; fetch_pc advances only on the gnt cycle.
- Two requests in flight (0x10, 0x14), redirect to 0x200 -> both responses dropped, drop_cnt 2->0; next de_pc=0x200; no 0x10 or 0x14 ever reaches de_valid.
- Redirect in the same cycle as rvalid, plus a second redirect to 0x300 during DRAIN -> correct drop counts; first delivered PC=0x300.
- rst_n asserted mid-DRAIN, then released -> all outputs return to reset values; fetch restarts at RESET_PC.
